// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the sector responder.
package sd_resp_pkg;

    localparam int unsigned SECTOR_WORDS = 256;
    localparam int unsigned WORD_W       = 16;

    typedef enum logic [3:0] {
        StIdle,
        StDelay,
        StRdMem,
        StRdPush,
        StWrAddr,
        StWrWait,
        StWrCap,
        StWrMem,
        StDone
    } state_e;

endpackage

// File: rtl/sd_req_edge.sv
// Rising-edge detector for the sector request lines; read wins when both rise together.
module sd_req_edge (
    input  logic clk_i,
    input  logic armed_i,
    input  logic rd_i,
    input  logic wr_i,
    output logic req_valid_o,
    output logic req_is_read_o
);

    logic old_rd_q;
    logic old_wr_q;
    logic rd_rise;
    logic wr_rise;

    // Tracked even through reset so a level held across reset never looks like a new edge.
    always_ff @(posedge clk_i) begin
        old_rd_q <= rd_i;
        old_wr_q <= wr_i;
    end

    assign rd_rise       = rd_i & ~old_rd_q;
    assign wr_rise       = wr_i & ~old_wr_q;
    assign req_valid_o   = armed_i & (rd_rise | wr_rise);
    assign req_is_read_o = rd_rise;

endmodule

// File: rtl/sd_sector_responder.sv
// Sector responder: moves one 256-word sector per request between the core's buffer
// and a backing word memory, one handshaked memory access per word.
module sd_sector_responder
    import sd_resp_pkg::*;
#(
    parameter int unsigned LBA_BITS  = 4,
    parameter int unsigned ACK_DELAY = 2,
    parameter int unsigned MEM_AW    = LBA_BITS + 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [7:0]        sd_buff_addr,
    output logic [15:0]       sd_buff_dout,
    input  logic [15:0]       sd_buff_din,
    output logic              sd_buff_wr,
    input  logic              wr_protect,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              prot_err
);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [7:0]            word_q, word_d;
    logic [LBA_BITS-1:0]   lba_q, lba_d;
    logic                  is_read_q, is_read_d;
    logic                  prot_q, prot_d;
    logic                  ack_q, ack_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  buff_wr_q, buff_wr_d;
    logic [7:0]            buff_addr_q, buff_addr_d;
    logic [WORD_W-1:0]     buff_dout_q, buff_dout_d;
    logic [WORD_W-1:0]     mem_din_q, mem_din_d;
    logic                  prot_err_q, prot_err_d;
    logic                  req_valid, req_is_read;
    logic [7:0]            word_inc;
    logic                  last_word;
    logic                  lba_unused;

    sd_req_edge u_req_edge (
        .clk_i         (clk_sys),
        .armed_i       (state_q == StIdle),
        .rd_i          (sd_rd),
        .wr_i          (sd_wr),
        .req_valid_o   (req_valid),
        .req_is_read_o (req_is_read)
    );

    assign word_inc   = word_q + 8'd1;
    assign last_word  = (word_q == 8'(SECTOR_WORDS - 1));
    assign lba_unused = ^sd_lba[31:LBA_BITS];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        lba_d       = lba_q;
        is_read_d   = is_read_q;
        prot_d      = prot_q;
        ack_d       = ack_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        buff_wr_d   = 1'b0;
        buff_addr_d = buff_addr_q;
        buff_dout_d = buff_dout_q;
        mem_din_d   = mem_din_q;
        prot_err_d  = prot_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d   = StDelay;
                    cnt_d     = 4'd0;
                    word_d    = 8'd0;
                    lba_d     = sd_lba[LBA_BITS-1:0];
                    is_read_d = req_is_read;
                    prot_d    = !req_is_read && wr_protect;
                    if (!req_is_read && wr_protect) prot_err_d = 1'b1;
                end
            end
            StDelay: begin
                if (cnt_q == 4'(ACK_DELAY)) begin
                    ack_d = 1'b1;
                    if (is_read_q) begin
                        state_d  = StRdMem;
                        mem_rd_d = 1'b1;
                    end else begin
                        state_d     = StWrAddr;
                        buff_addr_d = word_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRdMem: begin
                if (mem_rdy) begin
                    mem_rd_d    = 1'b0;
                    buff_wr_d   = 1'b1;
                    buff_addr_d = word_q;
                    buff_dout_d = mem_dout;
                    state_d     = StRdPush;
                end
            end
            StRdPush: begin
                word_d = word_inc;
                if (last_word) begin
                    state_d = StDone;
                end else begin
                    state_d  = StRdMem;
                    mem_rd_d = 1'b1;
                end
            end
            StWrAddr: state_d = StWrWait;
            StWrWait: state_d = StWrCap;
            StWrCap: begin
                // Protected transfers still walk every buffer word but never touch memory.
                if (prot_q) begin
                    word_d = word_inc;
                    if (last_word) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StWrAddr;
                        buff_addr_d = word_inc;
                    end
                end else begin
                    mem_din_d = sd_buff_din;
                    mem_wr_d  = 1'b1;
                    state_d   = StWrMem;
                end
            end
            StWrMem: begin
                if (mem_rdy) begin
                    mem_wr_d = 1'b0;
                    word_d   = word_inc;
                    if (last_word) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StWrAddr;
                        buff_addr_d = word_inc;
                    end
                end
            end
            StDone: begin
                ack_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            word_q      <= 8'd0;
            lba_q       <= '0;
            is_read_q   <= 1'b0;
            prot_q      <= 1'b0;
            ack_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            buff_wr_q   <= 1'b0;
            buff_addr_q <= 8'd0;
            buff_dout_q <= '0;
            mem_din_q   <= '0;
            prot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            lba_q       <= lba_d;
            is_read_q   <= is_read_d;
            prot_q      <= prot_d;
            ack_q       <= ack_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            buff_wr_q   <= buff_wr_d;
            buff_addr_q <= buff_addr_d;
            buff_dout_q <= buff_dout_d;
            mem_din_q   <= mem_din_d;
            prot_err_q  <= prot_err_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = buff_addr_q;
    assign sd_buff_dout = buff_dout_q;
    assign sd_buff_wr   = buff_wr_q;
    assign mem_addr     = MEM_AW'({lba_q, word_q});
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_din      = mem_din_q;
    assign busy         = (state_q != StIdle);
    assign prot_err     = prot_err_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Self-checking bench for sd_sector_responder: backing memory, dpram and sector model.
module tb_sd_sector_responder;

    localparam int unsigned LBA_BITS  = 4;
    localparam int unsigned ACK_DELAY = 2;
    localparam int unsigned MEM_AW    = LBA_BITS + 8;
    localparam int unsigned DEPTH     = 1 << MEM_AW;
    localparam int READ_FALL = 2 * 256 + 1;
    localparam int PROT_FALL = 3 * 256 + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       sd_lba;
    logic              sd_rd, sd_wr, sd_ack, sd_buff_wr, wr_protect;
    logic [7:0]        sd_buff_addr;
    logic [15:0]       sd_buff_dout, sd_buff_din, mem_din, mem_dout;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd, mem_wr, mem_rdy, busy, prot_err;

    logic [15:0] bmem    [DEPTH];
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] dpram   [256];

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;  // 0 always ready, 1 random 1-3 cycles, 2 stall forever at word 100
    int lat = 0;
    int wr_pulses, busy_cnt, hold_viol, both_high;
    logic mem_wr_prev = 1'b0;
    logic pend_prev = 1'b0, pend_rd, pend_wr;
    logic [MEM_AW-1:0] pend_addr;
    logic [7:0]  strobe_addr_q[$];
    logic [15:0] strobe_data_q[$];
    logic [MEM_AW-1:0] acc_addr_q[$];

    always #5 clk = ~clk;

    sd_sector_responder #(
        .LBA_BITS  (LBA_BITS),
        .ACK_DELAY (ACK_DELAY),
        .MEM_AW    (MEM_AW)
    ) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .wr_protect   (wr_protect),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .mem_rdy      (mem_rdy),
        .busy         (busy),
        .prot_err     (prot_err)
    );

    assign mem_dout = bmem[mem_addr];

    always @(posedge clk) sd_buff_din <= dpram[sd_buff_addr];

    // Memory responder and protocol monitor, evaluated 2ns after each rising edge.
    always @(posedge clk) begin
        #2;
        if (pend_prev && !reset) begin
            if (mem_rd !== pend_rd || mem_wr !== pend_wr || mem_addr !== pend_addr) hold_viol++;
        end
        if (mem_rd && mem_wr) both_high++;
        if (mem_wr && !mem_wr_prev) wr_pulses++;
        mem_wr_prev = mem_wr;
        if (busy) busy_cnt++;
        if (sd_buff_wr === 1'b1) begin
            strobe_addr_q.push_back(sd_buff_addr);
            strobe_data_q.push_back(sd_buff_dout);
        end
        if (rdy_mode == 0) begin
            mem_rdy = 1'b1;
        end else if (rdy_mode == 2) begin
            mem_rdy = !(mem_rd && mem_addr[7:0] == 8'd100);
        end else if (mem_rd || mem_wr) begin
            if (lat == 0) lat = int'($urandom_range(1, 3));
            lat = lat - 1;
            mem_rdy = (lat == 0);
        end else begin
            lat = 0;
            mem_rdy = 1'b0;
        end
        if ((mem_rd || mem_wr) && mem_rdy && !reset) begin
            acc_addr_q.push_back(mem_addr);
            if (mem_wr) bmem[mem_addr] = mem_din;
        end
        pend_prev = (mem_rd || mem_wr) && !mem_rdy;
        pend_rd   = mem_rd;
        pend_wr   = mem_wr;
        pend_addr = mem_addr;
    end

    task automatic clear_mon;
        strobe_addr_q.delete();
        strobe_data_q.delete();
        acc_addr_q.delete();
        wr_pulses = 0;
        busy_cnt  = 0;
        hold_viol = 0;
        both_high = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0; wr_protect = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drops the requested lines, raises them, and measures ack rise/fall edge counts.
    task automatic run_xfer(input bit rd, input bit wr, input logic [31:0] lba,
                            output int rise, output int fall);
        @(negedge clk);
        if (rd) sd_rd = 1'b0;
        if (wr) sd_wr = 1'b0;
        @(negedge clk);
        clear_mon();
        sd_lba = lba;
        if (rd) sd_rd = 1'b1;
        if (wr) sd_wr = 1'b1;
        @(posedge clk); #1;
        rise = 0;
        while (!sd_ack && rise < 64) begin @(posedge clk); #1; rise++; end
        fall = 0;
        while (sd_ack && fall < 4000) begin @(posedge clk); #1; fall++; end
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({sd_ack, busy, mem_rd, mem_wr, sd_buff_wr, prot_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {sd_ack, busy, mem_rd, mem_wr, sd_buff_wr, prot_err});
        end
        checks++;
        if ({mem_addr, sd_buff_addr, sd_buff_dout, mem_din} !== '0) begin
            failures++;
            $display("FAIL reset_data: addr=%h baddr=%h bdout=%h mdin=%h want all 0",
                     mem_addr, sd_buff_addr, sd_buff_dout, mem_din);
        end
    endtask

    task automatic test_read;
        int rise, fall;
        rdy_mode = 0;
        run_xfer(1'b1, 1'b0, 32'd3, rise, fall);
        checks++;
        if (rise != int'(ACK_DELAY) + 1) begin
            failures++; $display("FAIL read_ack_rise: got %0d want %0d", rise, ACK_DELAY + 1);
        end
        checks++;
        if (fall != READ_FALL) begin
            failures++; $display("FAIL read_ack_fall: got %0d want %0d", fall, READ_FALL);
        end
        checks++;
        if (strobe_addr_q.size() != 256) begin
            failures++; $display("FAIL read_strobes: got %0d want 256", strobe_addr_q.size());
        end
        for (int i = 0; i < strobe_addr_q.size() && i < 256; i++) begin
            checks++;
            if (strobe_addr_q[i] !== 8'(i) ||
                strobe_data_q[i] !== 16'((32'h300 + i) ^ 32'hA5A5)) begin
                failures++;
                $display("FAIL read_word[%0d]: got addr=%h data=%h want addr=%h data=%h", i,
                         strobe_addr_q[i], strobe_data_q[i], 8'(i),
                         16'((32'h300 + i) ^ 32'hA5A5));
            end
        end
        checks++;
        if (wr_pulses != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL read_side: got wr_pulses=%0d busy=%b want 0 0",
                                 wr_pulses, busy);
        end
    endtask

    task automatic test_read_random;
        int rise, fall;
        logic [31:0] lba;
        lba = $urandom;
        for (int i = 0; i < 256; i++) begin
            bmem[{lba[LBA_BITS-1:0], 8'(i)}]    = 16'($urandom);
            ref_mem[{lba[LBA_BITS-1:0], 8'(i)}] = bmem[{lba[LBA_BITS-1:0], 8'(i)}];
        end
        rdy_mode = 1;
        run_xfer(1'b1, 1'b0, lba, rise, fall);
        checks++;
        if (rise != int'(ACK_DELAY) + 1 || fall >= 4000) begin
            failures++; $display("FAIL rread_ack: got rise=%0d fall=%0d want rise=%0d fall<4000",
                                 rise, fall, ACK_DELAY + 1);
        end
        checks++;
        if (strobe_addr_q.size() != 256 || hold_viol != 0 || both_high != 0) begin
            failures++; $display("FAIL rread_proto: got strobes=%0d hold=%0d both=%0d want 256 0 0",
                                 strobe_addr_q.size(), hold_viol, both_high);
        end
        for (int i = 0; i < strobe_addr_q.size() && i < 256; i++) begin
            checks++;
            if (strobe_addr_q[i] !== 8'(i) ||
                strobe_data_q[i] !== ref_mem[{lba[LBA_BITS-1:0], 8'(i)}]) begin
                failures++;
                $display("FAIL rread_word[%0d]: got addr=%h data=%h want addr=%h data=%h", i,
                         strobe_addr_q[i], strobe_data_q[i], 8'(i),
                         ref_mem[{lba[LBA_BITS-1:0], 8'(i)}]);
            end
        end
    endtask

    task automatic test_lba_wrap;
        int rise, fall;
        rdy_mode = 0;
        run_xfer(1'b1, 1'b0, 32'h0000_0013, rise, fall);
        checks++;
        if (acc_addr_q.size() != 256) begin
            failures++; $display("FAIL wrap_count: got %0d want 256", acc_addr_q.size());
        end
        for (int i = 0; i < acc_addr_q.size() && i < 256; i++) begin
            checks++;
            if (acc_addr_q[i] !== MEM_AW'(32'h300 + i)) begin
                failures++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, acc_addr_q[i],
                                     MEM_AW'(32'h300 + i));
            end
        end
    endtask

    task automatic test_write;
        int rise, fall;
        for (int i = 0; i < 256; i++) begin
            dpram[i] = 16'(32'h1000 + i);
            ref_mem[32'h500 + i] = 16'(32'h1000 + i);
        end
        rdy_mode = 1;
        run_xfer(1'b0, 1'b1, 32'd5, rise, fall);
        checks++;
        if (rise != int'(ACK_DELAY) + 1 || fall >= 4000) begin
            failures++; $display("FAIL write_ack: got rise=%0d fall=%0d want rise=%0d fall<4000",
                                 rise, fall, ACK_DELAY + 1);
        end
        checks++;
        if (strobe_addr_q.size() != 0 || wr_pulses != 256 || hold_viol != 0 || both_high != 0) begin
            failures++;
            $display("FAIL write_proto: got strobes=%0d wr=%0d hold=%0d both=%0d want 0 256 0 0",
                     strobe_addr_q.size(), wr_pulses, hold_viol, both_high);
        end
        checks++;
        if (prot_err !== 1'b0) begin
            failures++; $display("FAIL write_prot_err: got %b want 0", prot_err);
        end
        for (int a = 0; a < int'(DEPTH); a++) begin
            checks++;
            if (bmem[a] !== ref_mem[a]) begin
                failures++; $display("FAIL write_mem[%h]: got %h want %h", a, bmem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic test_protect;
        int rise, fall;
        for (int i = 0; i < 256; i++) dpram[i] = 16'($urandom);
        rdy_mode = 0;
        wr_protect = 1'b1;
        run_xfer(1'b0, 1'b1, $urandom, rise, fall);
        checks++;
        if (prot_err !== 1'b1) begin
            failures++; $display("FAIL prot_flag: got %b want 1", prot_err);
        end
        checks++;
        if (rise != int'(ACK_DELAY) + 1 || fall != PROT_FALL || wr_pulses != 0) begin
            failures++; $display("FAIL prot_cycle: got rise=%0d fall=%0d wr=%0d want %0d %0d 0",
                                 rise, fall, wr_pulses, ACK_DELAY + 1, PROT_FALL);
        end
        for (int a = 0; a < int'(DEPTH); a++) begin
            checks++;
            if (bmem[a] !== ref_mem[a]) begin
                failures++; $display("FAIL prot_mem[%h]: got %h want %h", a, bmem[a], ref_mem[a]);
            end
        end
        wr_protect = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (prot_err !== 1'b1) begin
            failures++; $display("FAIL prot_sticky: got %b want 1", prot_err);
        end
        do_reset();
        checks++;
        if (prot_err !== 1'b0) begin
            failures++; $display("FAIL prot_clear: got %b want 0", prot_err);
        end
    endtask

    task automatic test_simultaneous;
        int rise, fall;
        logic [31:0] lba;
        rdy_mode = 0;
        lba = $urandom;
        run_xfer(1'b1, 1'b1, lba, rise, fall);
        checks++;
        if (strobe_addr_q.size() != 256 || wr_pulses != 0 || fall != READ_FALL) begin
            failures++; $display("FAIL both_rise: got strobes=%0d wr=%0d fall=%0d want 256 0 %0d",
                                 strobe_addr_q.size(), wr_pulses, fall, READ_FALL);
        end
        for (int i = 0; i < strobe_addr_q.size() && i < 256; i++) begin
            checks++;
            if (strobe_data_q[i] !== ref_mem[{lba[LBA_BITS-1:0], 8'(i)}]) begin
                failures++; $display("FAIL both_word[%0d]: got %h want %h", i, strobe_data_q[i],
                                     ref_mem[{lba[LBA_BITS-1:0], 8'(i)}]);
            end
        end
        busy_cnt = 0;
        repeat (40) @(negedge clk);
        checks++;
        if (busy_cnt != 0) begin
            failures++; $display("FAIL retrigger_held: got busy cycles=%0d want 0", busy_cnt);
        end
        run_xfer(1'b1, 1'b0, lba, rise, fall);
        checks++;
        if (strobe_addr_q.size() != 256 || wr_pulses != 0) begin
            failures++; $display("FAIL retrigger_toggle: got strobes=%0d wr=%0d want 256 0",
                                 strobe_addr_q.size(), wr_pulses);
        end
    endtask

    task automatic test_reset_mid_read;
        int rise, fall, n;
        logic [31:0] lba;
        lba = $urandom;
        rdy_mode = 2;
        @(negedge clk); sd_rd = 1'b0;
        @(negedge clk); clear_mon(); sd_lba = lba; sd_rd = 1'b1;
        n = 0;
        while (!(mem_rd && mem_addr[7:0] == 8'd100) && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 2000) begin
            failures++; $display("FAIL midrst_reach: got timeout want mem_rd at word 100");
        end
        repeat (2) @(negedge clk);
        checks++;
        if (strobe_addr_q.size() != 100 || mem_rd !== 1'b1) begin
            failures++; $display("FAIL midrst_pending: got strobes=%0d mem_rd=%b want 100 1",
                                 strobe_addr_q.size(), mem_rd);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({sd_ack, mem_rd, busy} !== 3'b000) begin
            failures++; $display("FAIL midrst_drop: got ack/rd/busy=%b want 000",
                                 {sd_ack, mem_rd, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        rdy_mode = 0;
        clear_mon();
        repeat (20) @(negedge clk);
        checks++;
        if (strobe_addr_q.size() != 0 || busy_cnt != 0) begin
            failures++; $display("FAIL midrst_late: got strobes=%0d busy=%0d want 0 0",
                                 strobe_addr_q.size(), busy_cnt);
        end
        run_xfer(1'b1, 1'b0, lba, rise, fall);
        checks++;
        if (strobe_addr_q.size() != 256 || fall != READ_FALL) begin
            failures++; $display("FAIL midrst_restart: got strobes=%0d fall=%0d want 256 %0d",
                                 strobe_addr_q.size(), fall, READ_FALL);
        end
        for (int i = 0; i < strobe_addr_q.size() && i < 256; i++) begin
            checks++;
            if (strobe_addr_q[i] !== 8'(i) ||
                strobe_data_q[i] !== ref_mem[{lba[LBA_BITS-1:0], 8'(i)}]) begin
                failures++; $display("FAIL midrst_word[%0d]: got addr=%h data=%h want %h %h", i,
                                     strobe_addr_q[i], strobe_data_q[i], 8'(i),
                                     ref_mem[{lba[LBA_BITS-1:0], 8'(i)}]);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sd_lba = '0; sd_rd = 1'b0; sd_wr = 1'b0; wr_protect = 1'b0;
        mem_rdy = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            bmem[a]    = 16'(a) ^ 16'hA5A5;
            ref_mem[a] = 16'(a) ^ 16'hA5A5;
        end
        for (int i = 0; i < 256; i++) dpram[i] = '0;
        test_reset();
        test_read();
        test_read_random();
        test_lba_wrap();
        test_write();
        test_protect();
        test_simultaneous();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
